// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor: opcodes, control FSM states,
// instruction field positions and matrix geometry.
package coproc_pkg;

  localparam int unsigned ROWS   = 5;
  localparam int unsigned ROW_W  = 40;
  localparam int unsigned MAT_W  = 200;
  localparam int unsigned ADDR_W = 6;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_MUL     = 4'b0101;
  localparam logic [3:0] OP_TRANSP  = 4'b0110;
  localparam logic [3:0] OP_OPOSTA  = 4'b0111;
  localparam logic [3:0] OP_ESCALAR = 4'b1000;
  localparam logic [3:0] OP_DET2    = 4'b1001;
  localparam logic [3:0] OP_DET3    = 4'b1010;
  localparam logic [3:0] OP_DET4    = 4'b1011;
  localparam logic [3:0] OP_DET5    = 4'b1100;

  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned ESC_LSB  = 4;
  localparam int unsigned ADRA_LSB = 12;
  localparam int unsigned ADRB_LSB = 18;
  localparam int unsigned ADRC_LSB = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WRITE,
    ST_RELEASE
  } state_t;

  function automatic logic is_binary(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  function automatic logic is_unary(input logic [3:0] op);
    return (op >= OP_TRANSP) && (op <= OP_DET5);
  endfunction

endpackage

// File: rtl/unidade_controle.sv
// Control stage ahead of the matrix ALU: decodes one instruction, fetches the
// operand rows, runs the ALU handshake and writes the 5-row result back.
module unidade_controle
  import coproc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [ROW_W-1:0]  mem_wdata,
  input  logic [ROW_W-1:0]  mem_rdata,
  output logic [3:0]        alu_opcode,
  output logic [7:0]        alu_escalar,
  output logic [MAT_W-1:0]  alu_matrizA,
  output logic [MAT_W-1:0]  alu_matrizB,
  output logic              alu_start,
  input  logic [MAT_W-1:0]  alu_resultado,
  input  logic              alu_done,
  input  logic              alu_overflow,
  output logic              busy,
  output logic              op_done,
  output logic              overflow,
  output logic              error
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t              state_q, state_d;
  logic [3:0]          op_q;
  logic [7:0]          esc_q;
  logic [ADDR_W-1:0]   addr_a_q, addr_b_q, addr_c_q;
  logic [3:0]          k_q;
  logic [TW-1:0]       tmo_q;
  logic [MAT_W-1:0]    mat_a_q, mat_b_q, res_q;
  logic                ovf_q, err_q;
  logic [3:0]          n_rows;
  logic [3:0]          instr_op;
  logic                accept, timeout_hit;

  assign instr_op    = instr[OP_LSB +: 4];
  assign accept      = (state_q == ST_IDLE) && instr_valid;
  assign n_rows      = is_binary(op_q) ? 4'd10 : 4'd5;
  assign timeout_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  assign alu_opcode  = op_q;
  assign alu_escalar = esc_q;
  assign alu_matrizA = mat_a_q;
  assign alu_matrizB = mat_b_q;
  assign overflow    = ovf_q;
  assign error       = err_q;
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    alu_start   = 1'b0;
    op_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_d = (is_binary(instr_op) || is_unary(instr_op)) ? ST_FETCH : ST_RELEASE;
      end
      ST_FETCH: begin
        if (k_q < n_rows)
          mem_addr = (k_q < 4'd5) ? addr_a_q + ADDR_W'(k_q)
                                  : addr_b_q + ADDR_W'(k_q - 4'd5);
        if (k_q == n_rows)
          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_start = 1'b1;
        if (alu_done)
          state_d = ST_WRITE;
        else if (timeout_hit)
          state_d = ST_RELEASE;
      end
      ST_WRITE: begin
        alu_start = 1'b1;
        // Gated by reset so an abort in WRITE suppresses the current row too.
        mem_we    = !reset;
        mem_addr  = addr_c_q + ADDR_W'(k_q);
        mem_wdata = res_q[ROW_W*int'(k_q) +: ROW_W];
        if (k_q == 4'd4)
          state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        op_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      esc_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
      k_q      <= '0;
      tmo_q    <= '0;
      mat_a_q  <= '0;
      mat_b_q  <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= instr_op;
            esc_q    <= instr[ESC_LSB +: 8];
            addr_a_q <= instr[ADRA_LSB +: ADDR_W];
            addr_b_q <= instr[ADRB_LSB +: ADDR_W];
            addr_c_q <= instr[ADRC_LSB +: ADDR_W];
            mat_b_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= !(instr_op == OP_NOP || is_binary(instr_op) || is_unary(instr_op));
            k_q      <= '0;
            tmo_q    <= '0;
          end
        end
        ST_FETCH: begin
          // RAM data lags the address by one cycle, so row k-1 lands at step k.
          if (k_q != 4'd0) begin
            if (k_q <= 4'd5)
              mat_a_q[ROW_W*(int'(k_q) - 1) +: ROW_W] <= mem_rdata;
            else
              mat_b_q[ROW_W*(int'(k_q) - 6) +: ROW_W] <= mem_rdata;
          end
          k_q <= (k_q == n_rows) ? 4'd0 : k_q + 4'd1;
        end
        ST_EXEC: begin
          tmo_q <= tmo_q + TW'(1);
          if (alu_done) begin
            res_q <= alu_resultado;
            ovf_q <= alu_overflow;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end
        end
        ST_WRITE: k_q <= k_q + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Randomised bench for unidade_controle with a row RAM model, a latency-
// programmable ALU model and a reference memory image updated per instruction.
module tb_unidade_controle;
  import coproc_pkg::*;

  localparam int unsigned TMO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [ROW_W-1:0]  mem_wdata;
  logic [ROW_W-1:0]  mem_rdata;
  logic [3:0]        alu_opcode;
  logic [7:0]        alu_escalar;
  logic [MAT_W-1:0]  alu_matrizA, alu_matrizB;
  logic              alu_start;
  logic [MAT_W-1:0]  alu_resultado;
  logic              alu_done;
  logic              alu_overflow;
  logic              busy, op_done, overflow, error;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [ROW_W-1:0] mem     [64];
  logic [ROW_W-1:0] mem_ref [64];
  bit               sync_req = 1'b0;

  int unsigned alu_lat  = 0;
  int unsigned alu_cnt  = 0;
  bit          alu_hang = 1'b0;
  bit          alu_ovf  = 1'b0;

  unidade_controle #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .alu_opcode(alu_opcode),
    .alu_escalar(alu_escalar), .alu_matrizA(alu_matrizA), .alu_matrizB(alu_matrizB),
    .alu_start(alu_start), .alu_resultado(alu_resultado), .alu_done(alu_done),
    .alu_overflow(alu_overflow), .busy(busy), .op_done(op_done),
    .overflow(overflow), .error(error)
  );

  always #5 clk = ~clk;

  // Environment ALU: byte-wise arithmetic for binary ops, a position-dependent
  // mix for unary ops so misplaced rows or elements show up in the result.
  function automatic logic [MAT_W-1:0] alu_fn(input logic [3:0] op, input logic [7:0] esc,
                                              input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    logic [MAT_W-1:0] r;
    logic [7:0] x, y;
    r = '0;
    for (int i = 0; i < 25; i++) begin
      x = a[8*i +: 8];
      y = b[8*i +: 8];
      case (op)
        OP_ADD:  r[8*i +: 8] = x + y;
        OP_SUB:  r[8*i +: 8] = x - y;
        OP_MUL:  r[8*i +: 8] = x * y;
        default: r[8*i +: 8] = (x ^ esc) + 8'(i) + {4'h0, op};
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (sync_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= mem_ref[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (!alu_start) begin
      alu_done     <= 1'b0;
      alu_cnt      <= 0;
      alu_overflow <= ~alu_ovf;
    end else if (!alu_hang && alu_cnt >= alu_lat) begin
      alu_done      <= 1'b1;
      alu_resultado <= alu_fn(alu_opcode, alu_escalar, alu_matrizA, alu_matrizB);
      alu_overflow  <= alu_ovf;
    end else begin
      alu_cnt      <= alu_cnt + 1;
      alu_overflow <= ~alu_ovf;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clk) sync_req = 1'b1;
    @(negedge clk) sync_req = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int unsigned bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== mem_ref[i]) bad++;
    check(tag, 64'(bad), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 64'(instr_ready), 64'd1);
    check({tag, "_outs"}, {busy, mem_we, alu_start, op_done, overflow, error,
                           |alu_matrizA, |alu_matrizB, |mem_addr, |alu_opcode}, 64'd0);
  endtask

  // Runs one instruction; abort_write >= 0 asserts reset in that WRITE row.
  task automatic run_op(input logic [31:0] ins, input int unsigned lat, input bit hang,
                        input bit ovf, input int abort_write);
    logic [3:0]       op;
    logic [5:0]       ea, eb, ec;
    logic [MAT_W-1:0] am, bm, rm;
    bit               bin, un, comp, nop, ill, timed_out;
    int unsigned      n, fetch, exec, wr, dones, addr_bad, b_bad, op_bad, waited;
    logic             err_seen, ovf_seen;
    op = ins[3:0]; ea = ins[17:12]; eb = ins[23:18]; ec = ins[29:24];
    bin  = (op == 4'd3 || op == 4'd4 || op == 4'd5);
    un   = (op >= 4'd6 && op <= 4'd12);
    comp = bin || un;
    nop  = (op == 4'd0);
    ill  = !comp && !nop;
    n    = bin ? 10 : (un ? 5 : 0);
    am = '0; bm = '0;
    for (int r = 0; r < 5; r++) begin
      am[40*r +: 40] = mem_ref[6'(ea + 6'(r))];
      if (bin) bm[40*r +: 40] = mem_ref[6'(eb + 6'(r))];
    end
    rm = alu_fn(op, ins[11:4], am, bm);
    alu_lat = lat; alu_hang = hang; alu_ovf = ovf;
    fetch = 0; exec = 0; wr = 0; dones = 0; addr_bad = 0; b_bad = 0; op_bad = 0;
    err_seen = 1'b0; ovf_seen = 1'b0; timed_out = 1'b1;

    waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 20) begin @(negedge clk); waited++; end
    check("idle_wait", 64'(instr_ready), 64'd1);
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr = $urandom;

    for (int c = 1; c <= 200; c++) begin
      if (busy && !alu_start && !op_done && !mem_we) fetch++;
      if (alu_start && !mem_we) begin
        exec++;
        if (un && alu_matrizB != '0) b_bad++;
        if (alu_opcode != op) op_bad++;
      end
      if (mem_we) begin
        if (mem_addr !== 6'(ec + 6'(wr))) addr_bad++;
        wr++;
      end
      if (op_done) begin
        dones++; err_seen = error; ovf_seen = overflow;
        if (nop) check("nop_latency", 64'(c), 64'd1);
        timed_out = 1'b0;
        break;
      end
      if (abort_write >= 0 && mem_we && wr == 32'(abort_write) + 1) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_quiet("abort");
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("op_finished", 64'(timed_out), 64'd0);

    if (abort_write >= 0) begin
      for (int r = 0; r < abort_write; r++) mem_ref[6'(ec + 6'(r))] = rm[40*r +: 40];
      check_mem("abort_mem");
    end else begin
      if (comp && !hang)
        for (int r = 0; r < 5; r++) mem_ref[6'(ec + 6'(r))] = rm[40*r +: 40];
      check("fetch_cycles", 64'(fetch), 64'(comp ? n + 1 : 0));
      check("exec_cycles", 64'(exec), 64'(!comp ? 0 : (hang ? TMO : lat + 2)));
      check("write_cycles", 64'(wr), 64'((comp && !hang) ? 5 : 0));
      check("write_addr", 64'(addr_bad), 64'd0);
      check("matB_zero", 64'(b_bad), 64'd0);
      check("opcode_held", 64'(op_bad), 64'd0);
      check("error_flag", 64'(err_seen), 64'(ill || (comp && hang)));
      check("overflow_flag", 64'(ovf_seen), 64'(comp && !hang && ovf));
      @(negedge clk);
      check("single_done", {63'(dones), op_done}, 64'd2);
      check_mem("result_mem");
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] esc,
                                     input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    return {2'b00, c, b, a, esc, op};
  endfunction

  initial begin
    reset = 1'b1; instr = '0; instr_valid = 1'b0;
    for (int i = 0; i < 64; i++) mem_ref[i] = {$urandom, $urandom};
    sync_req = 1'b1;
    repeat (3) @(negedge clk);
    sync_req = 1'b0;
    reset = 1'b0;
    check_quiet("reset");

    // Add of all-ones and all-twos
    for (int r = 0; r < 5; r++) begin
      mem_ref[r] = 40'h0101010101; mem_ref[5 + r] = 40'h0202020202;
    end
    load_mem();
    run_op(mk(OP_ADD, 8'h00, 6'd0, 6'd5, 6'd10), 1, 1'b0, 1'b0, -1);
    check("add_row10", 64'(mem[10]), 64'h0303030303);
    check("add_row14", 64'(mem[14]), 64'h0303030303);

    // Transpose with wrapping source
    run_op(mk(OP_TRANSP, 8'h5a, 6'd62, 6'd7, 6'd20), 2, 1'b0, 1'b0, -1);

    // Illegal opcode, then NOP clears error
    run_op(mk(4'hf, 8'h00, 6'd1, 6'd2, 6'd3), 0, 1'b0, 1'b0, -1);
    repeat (2) @(negedge clk);
    check("error_held", 64'(error), 64'd1);
    run_op(mk(OP_NOP, 8'h00, 6'd1, 6'd2, 6'd3), 0, 1'b0, 1'b0, -1);

    // ALU that never answers
    run_op(mk(OP_SUB, 8'h00, 6'd30, 6'd40, 6'd50), 0, 1'b1, 1'b0, -1);

    // 127+1 with overflow, result written in place over A
    mem_ref[33] = 40'h7f7f7f7f7f;
    for (int r = 0; r < 5; r++) mem_ref[40 + r] = 40'h0101010101;
    load_mem();
    run_op(mk(OP_ADD, 8'h00, 6'd33, 6'd40, 6'd33), 3, 1'b0, 1'b1, -1);
    check("inplace_row", 64'(mem[33]), 64'h8080808080);
    repeat (3) @(negedge clk);
    check("overflow_held", 64'(overflow), 64'd1);
    run_op(mk(OP_DET3, 8'h11, 6'd8, 6'd0, 6'd44), 6, 1'b0, 1'b0, -1);

    // Reset during the third write row, then a normal instruction
    run_op(mk(OP_MUL, 8'h00, 6'd12, 6'd18, 6'd0), 1, 1'b0, 1'b0, 2);
    run_op(mk(OP_ESCALAR, 8'h3c, 6'd60, 6'd0, 6'd61), 0, 1'b0, 1'b0, -1);

    for (int t = 0; t < 40; t++)
      run_op({$urandom} & 32'h3fff_ffff, $urandom_range(0, 6), ($urandom_range(0, 7) == 0),
             1'($urandom), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
